// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle of the serial adder; master drives requests, slave is the datapath.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  ready, busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output ready, busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_addsub_full_adder_cell.sv
// Single-bit full adder, the only arithmetic element of the serial datapath.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through one full-adder cell.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_addsub_if.slave  bus
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CMSB_IDX = CNT_W'((WIDTH > 1) ? (WIDTH - 2) : 0);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic             last_s;

  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_shift_s;
  logic [WIDTH-1:0] op_a_shift_s;
  logic [WIDTH-1:0] op_b_shift_s;
  logic             carry_r;
  logic             cmsb_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             done_r;
  logic             busy_r;
  logic             ready_r;

  logic             fa_sum_s;
  logic             fa_carry_s;

  full_adder_cell u_fa (
    .x     (op_a_r[0]),
    .y     (op_b_r[0]),
    .z     (carry_r),
    .sum   (fa_sum_s),
    .carry (fa_carry_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus accept/last-bit strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = DONE;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Right-shift views; the new sum bit enters the accumulator at the MSB
  always_comb begin
    acc_shift_s              = acc_r >> 1;
    acc_shift_s[WIDTH-1]     = fa_sum_s;
    op_a_shift_s             = op_a_r >> 1;
    op_b_shift_s             = op_b_r >> 1;
  end

  // Operand/carry shifting and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r  <= '0;
      op_b_r  <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      cmsb_r  <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      if (accept_s) begin
        // Subtraction is a + ~b + 1, so the inversion and the +1 happen here once
        op_a_r  <= bus.a;
        op_b_r  <= bus.sub ? ~bus.b : bus.b;
        carry_r <= bus.sub ? 1'b1 : bus.cin;
        cmsb_r  <= bus.sub ? 1'b1 : bus.cin;
        acc_r   <= '0;
        cnt_r   <= '0;
      end else if (state_r == RUN) begin
        op_a_r  <= op_a_shift_s;
        op_b_r  <= op_b_shift_s;
        acc_r   <= acc_shift_s;
        carry_r <= fa_carry_s;
        cnt_r   <= cnt_r + CNT_W'(1);
        if ((WIDTH > 1) && (cnt_r == CMSB_IDX)) begin
          cmsb_r <= fa_carry_s;
        end
      end
      if (last_s) begin
        sum_r  <= acc_shift_s;
        cout_r <= fa_carry_s;
        ovf_r  <= cmsb_r ^ fa_carry_s;
      end
      done_r  <= last_s;
      busy_r  <= (state_nxt_s == RUN);
      ready_r <= (state_nxt_s != RUN);
    end
  end

  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;
  assign bus.done     = done_r;
  assign bus.busy     = busy_r;
  assign bus.ready    = ready_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed vectors at WIDTH=8 and a WIDTH=1 instance.
module tb_serial_addsub;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q8[$];
  exp_t q1[$];

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(1)) bus1 ();

  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_addsub #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (rst_n && bus8.done) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w8_unexpected_done: got done=1 expected no result at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_sum", 64'(bus8.sum), 64'(e.sum));
        chk("w8_cout", 64'(bus8.cout), 64'(e.cout));
        chk("w8_overflow", 64'(bus8.overflow), 64'(e.ovf));
        chk("w8_done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Monitor for the 1-bit instance
  always @(negedge clk) begin
    if (rst_n && bus1.done) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w1_unexpected_done: got done=1 expected no result at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("w1_sum", 64'(bus1.sum), 64'(e.sum[0]));
        chk("w1_cout", 64'(bus1.cout), 64'(e.cout));
        chk("w1_overflow", 64'(bus1.overflow), 64'(e.ovf));
        chk("w1_done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sb,
                        input logic ci, input logic [7:0] es, input logic ec,
                        input logic eo, input logic push);
    @(negedge clk);
    bus8.a = a;
    bus8.b = b;
    bus8.sub = sb;
    bus8.cin = ci;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    if (push) q8.push_back('{es, ec, eo, cyc + 8});
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic wait_done8(output int busy_cnt);
    logic found;
    found = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus8.done) begin
        found = 1'b1;
        break;
      end
      if (bus8.busy) busy_cnt++;
      @(negedge clk);
    end
    chk("w8_done_seen", 64'(found), 64'(1));
  endtask

  initial begin
    int bc;
    logic found1;
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus8.ready), 64'(1));
    chk("rst_busy", 64'(bus8.busy), 64'(0));
    chk("rst_done", 64'(bus8.done), 64'(0));
    chk("rst_sum", 64'(bus8.sum), 64'(0));
    chk("rst_cout_ovf", 64'({bus8.cout, bus8.overflow}), 64'(0));
    rst_n = 1'b1;

    // Basic add with busy-length and latency checks
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
    chk("run_ready_low", 64'(bus8.ready), 64'(0));
    wait_done8(bc);
    chk("busy_cycles", 64'(bc), 64'(8));
    chk("busy_low_at_done", 64'(bus8.busy), 64'(0));
    @(negedge clk);
    chk("done_one_cycle", 64'(bus8.done), 64'(0));
    chk("idle_ready", 64'(bus8.ready), 64'(1));
    chk("sum_held_idle", 64'(bus8.sum), 64'(8'h10));

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1); wait_done8(bc);
    run_op(8'h01, 8'h01, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1); wait_done8(bc);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1); wait_done8(bc);
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1); wait_done8(bc);
    run_op(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b1); wait_done8(bc);

    // start pulsed mid-run with new operands must be ignored
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.sub = 1'b1; bus8.cin = 1'b1;
    bus8.start = 1'b1;
    chk("busy_when_ignored", 64'(bus8.busy), 64'(1));
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(bc);
    chk("ignored_sum_held", 64'(bus8.sum), 64'(8'h46));
    @(negedge clk);

    // Back-to-back: second request issued during the DONE cycle
    run_op(8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_done8(bc);
    chk("done_cycle_ready", 64'(bus8.ready), 64'(1));
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.sub = 1'b1; bus8.cin = 1'b0;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    q8.push_back('{8'hF0, 1'b0, 1'b0, cyc + 8});
    @(negedge clk);
    bus8.start = 1'b0;
    chk("b2b_busy", 64'(bus8.busy), 64'(1));
    wait_done8(bc);
    @(negedge clk);

    // Reset during RUN aborts the operation
    run_op(8'h33, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus8.busy), 64'(0));
    chk("abort_done", 64'(bus8.done), 64'(0));
    chk("abort_sum", 64'(bus8.sum), 64'(0));
    chk("abort_ready", 64'(bus8.ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    run_op(8'h64, 8'h64, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b1); wait_done8(bc);
    @(negedge clk);

    // 1-bit instance: 1 + 1 overflows and carries out
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.sub = 1'b0; bus1.cin = 1'b0;
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    q1.push_back('{8'h00, 1'b1, 1'b1, cyc + 1});
    @(negedge clk);
    bus1.start = 1'b0;
    found1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus1.done) begin
        found1 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("w1_done_seen", 64'(found1), 64'(1));

    repeat (3) @(negedge clk);
    chk("w8_queue_empty", 64'(q8.size()), 64'(0));
    chk("w1_queue_empty", 64'(q1.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor. It processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. Operands are latched on a start handshake. Results are held stable with a one-cycle done pulse. It is the area-minimal, multi-bit sequential successor to the team's combinational full-adder cell and is used where throughput is not critical.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..64)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready=1
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1), cin ignored
a  input  WIDTH  operand A, latched on accepted start
b  input  WIDTH  operand B, latched on accepted start
cin  input  1  carry-in for add mode, latched on accepted start
ready  output  1  high in IDLE and DONE states (start may be accepted)
busy  output  1  high in RUN state
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result register
cout  output  1  carry out of MSB (sub: 1 = no borrow)
overflow  output  1  two's-complement overflow

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, internal shift registers, counter and carry=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on a clk edge with start=1.
- RUN stays for exactly WIDTH edges, then -> DONE.
- DONE -> RUN if start=1, otherwise -> IDLE. DONE lasts exactly one cycle.
- Accept (edge t, start=1, ready=1):
  - opA <= a
  - opB <= sub ? ~b : b
  - carry <= sub ? 1 : cin
  - bit counter <= 0
  - sub latched for the whole operation
- Each RUN edge:
  - full_adder_cell(opA[0], opB[0], carry) -> bit sum s, carry c.
  - The accumulator shifts right with s entering at the MSB.
  - opA and opB shift right; carry <= c; counter increments.
  - On the edge where counter = WIDTH-2, the current carry (carry into the MSB) is captured as cmsb. For WIDTH=1, cmsb is the initial carry.
- Completion (edge t+WIDTH, the last RUN edge):
  - sum <= final accumulator value; cout <= c; overflow <= cmsb ^ c; done <= 1 for one cycle.
- Latency: done is visible in the cycle after edge t+WIDTH. Throughput is one result per WIDTH+1 cycles back-to-back, since start is accepted in the DONE cycle.
- sum, cout and overflow update only at completion. They hold between operations, including through IDLE and the next RUN.
- start while busy=1 is ignored; there is no queueing.
- Input changes on a, b, sub and cin after acceptance have no effect.
- Reset mid-RUN aborts the operation with no done pulse; all outputs return to reset values.
- Wrap-around: the result is modulo 2^WIDTH. The carry is reported only on cout.

Decomposition:
- Package serial_addsub_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits
  - CNT_W = max(1, clog2(WIDTH)) constant/function
- Sub-module full_adder_cell: ports x, y, z, sum, carry, purely combinational. Instantiated once, bit-exact with the existing full-adder truth table.

Test Plan:
- WIDTH=8, add, a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, overflow=0. done pulses exactly once, 8 cycles after the accept edge; busy high for 8 cycles.
- Add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Add a=0x01, b=0x01, cin=1 -> sum=0x03, cout=0.
- Add a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
- Sub a=0x05, b=0x07 with cin=1 -> sum=0xFE, cout=0, overflow=0, showing cin is ignored. Sub a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
- Handshake/boundaries:
  - start pulsed at RUN cycle 3 is ignored, and the result is unchanged.
  - start held during the DONE cycle is accepted back-to-back with ready=1; the second result is correct.
  - rst_n low at RUN cycle 4 -> busy=0, done never pulses, sum=0.
  - Re-run of an add afterwards is correct.
- WIDTH=1 build: a=1, b=1, cin=0 add -> sum=0, cout=1, overflow=1. done is 1 cycle after accept.
